// File: rtl/product_serializer_pkg.sv
//------------------------------------------------------------------------------
// Module   : product_serializer_pkg
// Brief    : Shared state encoding and default sizing for product_serializer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package product_serializer_pkg;

    // Default word width and bit-counter width
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 3;

    // Serializer state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_PAR   = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_reg_piso.sv
//------------------------------------------------------------------------------
// Module   : shift_reg_piso
// Brief    : WIDTH-bit parallel-in / serial-out register. A load takes
//            priority over a shift; shifting moves toward the LSB and fills the
//            MSB with zero, so the register drains to all-zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_reg_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             lsb
);

    logic [WIDTH-1:0] r_q;

    // Parallel load or right shift with zero fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (shift) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign lsb = r_q[0];

endmodule

`default_nettype wire

// File: rtl/product_serializer.sv
//------------------------------------------------------------------------------
// Module   : product_serializer
// Brief    : Accepts one parallel product word per valid/ready handshake and
//            shifts it out LSB first, one bit per clock, with frame-valid and
//            last-bit markers.
// Config   : SERIALIZER_PARITY_EN - when defined, appends one even-parity bit
//            (captured at load) after the data bits.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module product_serializer
    import product_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
`ifndef SERIALIZER_PARITY_EN
    localparam logic [CNT_W-1:0] C_PEN  = CNT_W'(WIDTH - 2);
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_ld;
    logic             w_shift;
    logic [WIDTH-1:0] w_ld_data;
`ifdef SERIALIZER_PARITY_EN
    logic             r_parity;
`endif

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid & in_ready;

    // Shift-register control. The serial output is the register LSB, so the
    // parity bit is presented by reloading the register with it after the
    // last data bit; every other frame cycle just shifts.
    always_comb begin
        w_ld      = w_accept;
        w_shift   = (r_state != ST_IDLE);
        w_ld_data = in_data;
`ifdef SERIALIZER_PARITY_EN
        if (r_state == ST_SHIFT && r_cnt == C_LAST) begin
            w_ld      = 1'b1;
            w_shift   = 1'b0;
            w_ld_data = {{(WIDTH-1){1'b0}}, r_parity};
        end
`endif
    end

    shift_reg_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .ld    (w_ld),
        .shift (w_shift),
        .d     (w_ld_data),
        .lsb   (ser_out)
    );

    // Frame FSM, bit counter and registered frame markers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_SHIFT;
                        r_cnt     <= '0;
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b0;
                        busy      <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
                        r_parity  <= ^in_data;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == C_LAST) begin
`ifdef SERIALIZER_PARITY_EN
                        r_state   <= ST_PAR;
                        ser_last  <= 1'b1;
`else
                        r_state   <= ST_IDLE;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                        busy      <= 1'b0;
`endif
                    end else begin
                        // Counter stops at the last bit so it never wraps
                        r_cnt    <= r_cnt + 1'b1;
`ifdef SERIALIZER_PARITY_EN
                        ser_last <= 1'b0;
`else
                        ser_last <= (r_cnt == C_PEN);
`endif
                    end
                end
                ST_PAR: begin
                    r_state   <= ST_IDLE;
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_product_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_product_serializer
// Brief    : Self-checking bench for product_serializer. Expected serial bits
//            come from the word value itself (bit i = (w >> i) & 1, parity =
//            popcount mod 2). Honours SERIALIZER_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_product_serializer;

    localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    int checks = 0;
    int errors = 0;

    product_serializer #(
        .WIDTH (WIDTH),
        .CNT_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Safety net in case the design stalls the stimulus
    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: frame bit idx of word w (data LSB first, then even parity)
    function automatic logic ref_bit(input logic [WIDTH-1:0] w, input int idx);
        if (idx < WIDTH)
            return ((w >> idx) & 1) != 0;
        else
            return ($countones(w) % 2) != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, ser_valid, 1'b0);
        chk({tag, "_busy"},  busy,      1'b0);
        chk({tag, "_ready"}, in_ready,  1'b1);
        chk({tag, "_last"},  ser_last,  1'b0);
        chk({tag, "_out"},   ser_out,   1'b0);
    endtask

    // Present a word and wait (bounded) for acceptance; optionally keep
    // in_valid asserted with a new data value afterwards
    task automatic start(input logic [WIDTH-1:0] w, input bit hold,
                         input logic [WIDTH-1:0] next_w);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_wait", n < 50, 1'b1);
        tick();
        if (hold) in_data = next_w;
        else      in_valid = 1'b0;
    endtask

    // Called at the first sample point after acceptance
    task automatic check_frame(input logic [WIDTH-1:0] w, input string tag);
        for (int i = 0; i < FRAME; i++) begin
            chk($sformatf("%s_v%0d", tag, i), ser_valid, 1'b1);
            chk($sformatf("%s_b%0d", tag, i), ser_out, ref_bit(w, i));
            chk($sformatf("%s_l%0d", tag, i), ser_last, i == FRAME - 1);
            chk($sformatf("%s_r%0d", tag, i), in_ready, 1'b0);
            chk($sformatf("%s_y%0d", tag, i), busy, 1'b1);
            tick();
        end
        chk({tag, "_end_valid"}, ser_valid, 1'b0);
        chk({tag, "_end_ready"}, in_ready,  1'b1);
        chk({tag, "_end_busy"},  busy,      1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int gap;

        // Power-on reset
        #1;
        check_idle("por");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle("post_rst");

        // Reset asserted while idle
        tick();
        rst = 1'b1;
        #1;
        check_idle("idle_rst");
        tick();
        rst = 1'b0;
        tick();

        // Basic frame 8'hA5
        start(8'hA5, 1'b0, 8'h00);
        check_frame(8'hA5, "a5");

        // Parity-distinguishing word (odd popcount)
        tick();
        start(8'h07, 1'b0, 8'h00);
        check_frame(8'h07, "w07");

        // Held in_valid: 8'h3C accepted, then 8'hFF waits for frame end + idle
        tick();
        start(8'h3C, 1'b1, 8'hFF);
        check_frame(8'h3C, "w3c");
        chk("gap_valid", ser_valid, 1'b0);
        tick();
        in_valid = 1'b0;
        check_frame(8'hFF, "wff");

        // Reset in the middle of 8'hF0 (while bit 4 is on the line)
        tick();
        start(8'hF0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f0_b%0d", i), ser_out, ref_bit(8'hF0, i));
            tick();
        end
        chk("f0_b4_pre", ser_out, 1'b1);
        rst = 1'b1;
        #1;
        check_idle("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        check_idle("after_mid_rst");
        start(8'h81, 1'b0, 8'h00);
        check_frame(8'h81, "w81");

        // Long idle with no requests
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("idle%0d_valid", i), ser_valid, 1'b0);
            chk($sformatf("idle%0d_busy", i),  busy,      1'b0);
            tick();
        end

        // Random words with random idle gaps
        for (int k = 0; k < 16; k++) begin
            w   = WIDTH'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            start(w, 1'b0, 8'h00);
            check_frame(w, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
